uart_rx_core: RTL and testbench

//  Serial receive engine for the UART device: 16x-oversampled async receiver, 8N1 by default.

---
 rtl/uart_rx_core.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// 16x-oversampled UART receiver: 2-flop sync, majority vote at ticks 7/8/9, valid/ready byte output.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
module uart_rx_core #(
   parameter int DATA_BITS = 8,
   parameter int DIV_W     = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic [DIV_W-1:0]     i_baud_div,
   input  logic                 i_uart_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   input  logic                 i_clr_ovr,
   output logic                 o_busy
`ifdef UART_RX_PARITY_EN
  ,input  logic                 i_parity_odd,
   output logic                 o_parity_err
`endif
);

   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI
   } state_t;

   state_t                 r_state;
   logic                   r_sync1, r_sync2, r_rx_d;
   logic [DIV_W-1:0]       r_tick_cnt;
   logic [3:0]             r_samp;
   logic [BW-1:0]          r_bit;
   logic                   r_s7, r_s8;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_dlv, r_dlv_ferr;
   logic                   w_fall, w_start, w_tick, w_maj;
   logic [3:0]             w_idx;
`ifdef UART_RX_PARITY_EN
   logic                   r_par, r_dlv_perr, w_perr;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_rx_d  <= 1'b1;
      end else begin
         r_sync1 <= i_uart_rx;
         r_sync2 <= r_sync1;
         r_rx_d  <= r_sync2;
      end
   end

   assign w_fall  = r_rx_d & ~r_sync2;
   assign w_start = (r_state == S_IDLE) && w_fall;
   assign w_tick  = (r_tick_cnt == '0) && !w_start;
   assign w_idx   = r_samp + 4'd1;
   assign w_maj   = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
`ifdef UART_RX_PARITY_EN
   assign w_perr  = ((^r_shift) ^ r_par) != i_parity_odd;
`endif

   // Reload on the start edge so every sample point is measured from the edge itself.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         r_tick_cnt <= '0;
      else if (w_start || r_tick_cnt == '0)
         r_tick_cnt <= i_baud_div;
      else
         r_tick_cnt <= r_tick_cnt - 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_samp     <= '0;
         r_bit      <= '0;
         r_s7       <= 1'b1;
         r_s8       <= 1'b1;
         r_shift    <= '0;
         r_dlv      <= 1'b0;
         r_dlv_ferr <= 1'b0;
         o_busy     <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par      <= 1'b0;
         r_dlv_perr <= 1'b0;
`endif
      end else begin
         r_dlv <= 1'b0;
         if (r_state != S_IDLE && w_tick) begin
            r_samp <= w_idx;
            if (w_idx == 4'd7) r_s7 <= r_sync2;
            if (w_idx == 4'd8) r_s8 <= r_sync2;
         end
         case (r_state)
            S_IDLE: begin
               if (w_fall) begin
                  r_state <= S_START;
                  r_samp  <= '0;
                  o_busy  <= 1'b1;
               end
            end
            S_START: begin
               if (w_tick && w_idx == 4'd9 && w_maj) begin
                  r_state <= S_IDLE;
                  o_busy  <= 1'b0;
               end else if (w_tick && w_idx == 4'd15) begin
                  r_state <= S_DATA;
                  r_bit   <= '0;
               end
            end
            S_DATA: begin
               if (w_tick && w_idx == 4'd9)
                  r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
               if (w_tick && w_idx == 4'd15) begin
                  if (r_bit == BIT_LAST)
`ifdef UART_RX_PARITY_EN
                     r_state <= S_PARITY;
`else
                     r_state <= S_STOP;
`endif
                  else
                     r_bit <= r_bit + 1'b1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (w_tick && w_idx == 4'd9) r_par <= w_maj;
               if (w_tick && w_idx == 4'd15) r_state <= S_STOP;
            end
`endif
            S_STOP: begin
               // Leave mid-stop so the next start edge is never missed.
               if (w_tick && w_idx == 4'd9) begin
                  r_dlv      <= 1'b1;
                  r_dlv_ferr <= ~w_maj;
`ifdef UART_RX_PARITY_EN
                  r_dlv_perr <= w_perr;
`endif
                  if (w_maj) begin
                     r_state <= S_IDLE;
                     o_busy  <= 1'b0;
                  end else begin
                     r_state <= S_WAIT_HI;
                  end
               end
            end
            S_WAIT_HI: begin
               if (r_sync2) begin
                  r_state <= S_IDLE;
                  o_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               o_busy  <= 1'b0;
            end
         endcase
      end
   end

   // A held byte is never overwritten; a new one arriving while held is dropped and flagged.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_data       <= '0;
         o_valid      <= 1'b0;
         o_frame_err  <= 1'b0;
         o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         o_parity_err <= 1'b0;
`endif
      end else begin
         if (r_dlv && (!o_valid || i_ready)) begin
            o_data       <= r_shift;
            o_frame_err  <= r_dlv_ferr;
            o_valid      <= 1'b1;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= r_dlv_perr;
`endif
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end
         o_overrun <= (o_overrun & ~i_clr_ovr) | (r_dlv & o_valid & ~i_ready);
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frames driven on the serial pin, bytes captured on handshake.
module tb_uart_rx_core;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] baud_div;
   logic        rx;
   logic [7:0]  o_data;
   logic        o_valid;
   logic        i_ready;
   logic        o_frame_err;
   logic        o_overrun;
   logic        i_clr_ovr;
   logic        o_busy;
`ifdef UART_RX_PARITY_EN
   logic        parity_odd;
   logic        o_parity_err;
   logic        tb_par;
`endif

   int checks   = 0;
   int failures = 0;
   logic [8:0] q[$];

   always #5 clk = ~clk;

   uart_rx_core #(.DATA_BITS(8), .DIV_W(16)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_baud_div  (baud_div),
      .i_uart_rx   (rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun),
      .i_clr_ovr   (i_clr_ovr),
      .o_busy      (o_busy)
`ifdef UART_RX_PARITY_EN
     ,.i_parity_odd(parity_odd),
      .o_parity_err(o_parity_err)
`endif
   );

   // Record every byte taken by the consumer as {frame_err, data}.
   always @(negedge clk)
      if (!rst && o_valid && i_ready) q.push_back({o_frame_err, o_data});

   // Caller must be at a negedge; leaves the line at the stop-bit level.
   task automatic drive_frame(input logic [7:0] b, input logic stopv, input int bitlen);
      rx = 1'b0;
      repeat (bitlen) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (bitlen) @(negedge clk);
      end
`ifdef UART_RX_PARITY_EN
      rx = tb_par;
      repeat (bitlen) @(negedge clk);
`endif
      rx = stopv;
      repeat (bitlen) @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks += 5;
      if (o_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", o_data); end
      if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
      if (o_frame_err !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b exp=0", o_frame_err); end
      if (o_overrun !== 1'b0) begin failures++; $display("FAIL reset_ovr got=%b exp=0", o_overrun); end
      if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
   endtask

   task automatic test_basic;
      int lat = 0;
      int exp_lat;
      logic pulse_ok = 1'b0;
      // 2 sync flops + edge register add 3 clk to the 9.6 bit-time (307 clk) sample point.
`ifdef UART_RX_PARITY_EN
      exp_lat = 342;
`else
      exp_lat = 310;
`endif
      q.delete();
      @(negedge clk);
      fork
         drive_frame(8'hA5, 1'b1, 32);
         begin
            while (!o_valid && lat < 500) begin @(posedge clk); #1; lat++; end
            @(posedge clk); #1;
            pulse_ok = !o_valid;
         end
      join
      repeat (8) @(negedge clk);
      checks += 6;
      if (lat < exp_lat - 2 || lat > exp_lat + 2) begin
         failures++; $display("FAIL basic_latency got=%0d exp=%0d+-2", lat, exp_lat);
      end
      if (!pulse_ok) begin failures++; $display("FAIL basic_pulse got=valid_held exp=1cycle"); end
      if (q.size() !== 1) begin failures++; $display("FAIL basic_count got=%0d exp=1", q.size()); end
      if (q.size() > 0 && q[0][7:0] !== 8'hA5) begin failures++; $display("FAIL basic_data got=%h exp=a5", q[0][7:0]); end
      if (q.size() > 0 && q[0][8] !== 1'b0) begin failures++; $display("FAIL basic_ferr got=%b exp=0", q[0][8]); end
      if (o_overrun !== 1'b0) begin failures++; $display("FAIL basic_ovr got=%b exp=0", o_overrun); end
   endtask

   task automatic test_glitch;
      int n = 0;
      logic busy_mid;
      q.delete();
      @(negedge clk);
      rx = 1'b0;
      repeat (8) @(negedge clk);
      busy_mid = o_busy;
      rx = 1'b1;
      while (o_busy && n < 20) begin @(posedge clk); #1; n++; end
      repeat (400) @(negedge clk);
      checks += 3;
      if (busy_mid !== 1'b1) begin failures++; $display("FAIL glitch_busy_mid got=%b exp=1", busy_mid); end
      if (o_busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_idle got=%b exp=0 within 20clk", o_busy); end
      if (q.size() !== 0) begin failures++; $display("FAIL glitch_noout got=%0d exp=0", q.size()); end
   endtask

   task automatic test_break;
      q.delete();
      @(negedge clk);
      drive_frame(8'h3C, 1'b0, 32);
      repeat (20 * 32) @(negedge clk);
      rx = 1'b1;
      repeat (64) @(negedge clk);
      checks += 3;
      if (q.size() !== 1) begin failures++; $display("FAIL break_count got=%0d exp=1", q.size()); end
      if (q.size() > 0 && q[0][7:0] !== 8'h3C) begin failures++; $display("FAIL break_data got=%h exp=3c", q[0][7:0]); end
      if (q.size() > 0 && q[0][8] !== 1'b1) begin failures++; $display("FAIL break_ferr got=%b exp=1", q[0][8]); end
      q.delete();
      drive_frame(8'h5A, 1'b1, 32);
      repeat (32) @(negedge clk);
      checks += 3;
      if (q.size() !== 1) begin failures++; $display("FAIL after_break_count got=%0d exp=1", q.size()); end
      if (q.size() > 0 && q[0][7:0] !== 8'h5A) begin failures++; $display("FAIL after_break_data got=%h exp=5a", q[0][7:0]); end
      if (q.size() > 0 && q[0][8] !== 1'b0) begin failures++; $display("FAIL after_break_ferr got=%b exp=0", q[0][8]); end
   endtask

   task automatic test_overrun;
      @(negedge clk);
      i_ready = 1'b0;
      drive_frame(8'h11, 1'b1, 32);
      drive_frame(8'h22, 1'b1, 32);
      repeat (40) @(negedge clk);
      checks += 4;
      if (o_valid !== 1'b1) begin failures++; $display("FAIL ovr_valid got=%b exp=1", o_valid); end
      if (o_data !== 8'h11) begin failures++; $display("FAIL ovr_data got=%h exp=11", o_data); end
      if (o_overrun !== 1'b1) begin failures++; $display("FAIL ovr_flag got=%b exp=1", o_overrun); end
      if (o_frame_err !== 1'b0) begin failures++; $display("FAIL ovr_ferr got=%b exp=0", o_frame_err); end
      i_ready = 1'b1;
      @(negedge clk);
      i_ready = 1'b0;
      @(negedge clk);
      checks += 2;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL ovr_take got=%b exp=0", o_valid); end
      if (o_overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b exp=1", o_overrun); end
      i_clr_ovr = 1'b1;
      @(negedge clk);
      i_clr_ovr = 1'b0;
      @(negedge clk);
      checks++;
      if (o_overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear got=%b exp=0", o_overrun); end
      i_ready = 1'b1;
      q.delete();
   endtask

   task automatic test_back_to_back;
      baud_div = 16'd0;
      repeat (8) @(negedge clk);
      q.delete();
      drive_frame(8'h00, 1'b1, 16);
      drive_frame(8'hFF, 1'b1, 16);
      repeat (40) @(negedge clk);
      checks += 5;
      if (q.size() !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", q.size()); end
      if (q.size() > 1 && q[0] !== 9'h000) begin failures++; $display("FAIL b2b_first got=%h exp=000", q[0]); end
      if (q.size() > 1 && q[1] !== 9'h0FF) begin failures++; $display("FAIL b2b_second got=%h exp=0ff", q[1]); end
      if (o_overrun !== 1'b0) begin failures++; $display("FAIL b2b_ovr got=%b exp=0", o_overrun); end
      if (o_busy !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%b exp=0", o_busy); end
      baud_div = 16'd1;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_reset_mid;
      logic busy_mid = 1'b0;
      logic [7:0] d_r = 8'hEE;
      logic v_r = 1'b1, f_r = 1'b1, o_r = 1'b1, b_r = 1'b1;
      q.delete();
      @(negedge clk);
      fork
         drive_frame(8'h77, 1'b1, 32);
         begin
            repeat (32 + 3 * 32 + 16) @(negedge clk);
            busy_mid = o_busy;
            rst = 1'b1;
            @(posedge clk); #1;
            d_r = o_data; v_r = o_valid; f_r = o_frame_err; o_r = o_overrun; b_r = o_busy;
         end
      join
      checks += 6;
      if (busy_mid !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", busy_mid); end
      if (d_r !== 8'h00) begin failures++; $display("FAIL rstmid_data got=%h exp=00", d_r); end
      if (v_r !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", v_r); end
      if (f_r !== 1'b0) begin failures++; $display("FAIL rstmid_ferr got=%b exp=0", f_r); end
      if (o_r !== 1'b0) begin failures++; $display("FAIL rstmid_ovr got=%b exp=0", o_r); end
      if (b_r !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", b_r); end
      rst = 1'b0;
      repeat (40) @(negedge clk);
      q.delete();
      drive_frame(8'h81, 1'b1, 32);
      repeat (32) @(negedge clk);
      checks += 2;
      if (q.size() !== 1) begin failures++; $display("FAIL rstmid_after_count got=%0d exp=1", q.size()); end
      if (q.size() > 0 && q[0] !== 9'h081) begin failures++; $display("FAIL rstmid_after_data got=%h exp=081", q[0]); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity;
      parity_odd = 1'b0;
      tb_par = 1'b0;
      @(negedge clk);
      drive_frame(8'h03, 1'b1, 32);
      repeat (32) @(negedge clk);
      checks++;
      if (o_parity_err !== 1'b0) begin failures++; $display("FAIL parity_ok got=%b exp=0", o_parity_err); end
      tb_par = 1'b1;
      drive_frame(8'h03, 1'b1, 32);
      repeat (32) @(negedge clk);
      checks++;
      if (o_parity_err !== 1'b1) begin failures++; $display("FAIL parity_bad got=%b exp=1", o_parity_err); end
      tb_par = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b1;
      baud_div = 16'd1;
      rx = 1'b1;
      i_ready = 1'b1;
      i_clr_ovr = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_odd = 1'b0;
      tb_par = 1'b0;
`endif
      test_reset();
      test_basic();
      test_glitch();
      test_break();
      test_overrun();
      test_back_to_back();
      test_reset_mid();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
